// File: rtl/mult_pkg.sv
// Constants shared by the multiplier-sharing arbiter: data widths, the default
// watchdog limit and the FSM state encoding.
package mult_pkg;

  localparam int MUL_W              = 8;
  localparam int PROD_W             = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around; returns both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = PTR_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential signed 8x8 multiplier between NUM_REQ requesters:
// round-robin grant, operand hand-off, start/done sequencing, watchdog abort.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PTR_W          = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [MUL_W*NUM_REQ-1:0] req_a,
  input  logic [MUL_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic signed [PROD_W-1:0] resp_product,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     mul_start,
  output logic signed [MUL_W-1:0]  mul_a,
  output logic signed [MUL_W-1:0]  mul_b,
  input  logic                     mul_done,
  input  logic signed [PROD_W-1:0] mul_product
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);

  logic [2:0]               r_state;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [PTR_W-1:0]         r_owner;
  logic [TMR_W-1:0]         r_timer;
  logic signed [PROD_W-1:0] r_result;
  logic                     r_err;
  logic [NUM_REQ-1:0]       r_req_ack;
  logic [NUM_REQ-1:0]       r_resp_valid;
  logic signed [PROD_W-1:0] r_resp_product;
  logic                     r_resp_err;
  logic                     r_busy;
  logic                     r_mul_start;
  logic signed [MUL_W-1:0]  r_mul_a;
  logic signed [MUL_W-1:0]  r_mul_b;

  logic [NUM_REQ-1:0]       w_grant;
  logic [PTR_W-1:0]         w_idx;
  logic                     w_any;
  logic [PTR_W-1:0]         w_next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_next_ptr = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_timer        <= '0;
      r_result       <= '0;
      r_err          <= 1'b0;
      r_req_ack      <= '0;
      r_resp_valid   <= '0;
      r_resp_product <= '0;
      r_resp_err     <= 1'b0;
      r_busy         <= 1'b0;
      r_mul_start    <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
    end else begin
      r_req_ack    <= '0;
      r_resp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_req_ack <= w_grant;
            r_owner   <= w_idx;
            r_mul_a   <= req_a[w_idx*MUL_W +: MUL_W];
            r_mul_b   <= req_b[w_idx*MUL_W +: MUL_W];
            r_rr_ptr  <= w_next_ptr;
            r_busy    <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end
        // Operands settle for one idle cycle before start is raised.
        ST_LOAD: begin
          r_mul_start <= 1'b1;
          r_timer     <= '0;
          r_state     <= ST_RUN;
        end
        // done in the first RUN cycle may be left over from the previous op.
        ST_RUN: begin
          if (mul_done && (r_timer != '0)) begin
            r_result    <= mul_product;
            r_err       <= 1'b0;
            r_mul_start <= 1'b0;
            r_state     <= ST_DRAIN;
          end else if (r_timer == TMR_LAST) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_mul_start <= 1'b0;
            r_state     <= ST_DRAIN;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_err || !mul_done) begin
            r_resp_valid   <= NUM_REQ'(1) << r_owner;
            r_resp_product <= r_result;
            r_resp_err     <= r_err;
            r_state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_mul_start <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack      = r_req_ack;
  assign resp_valid   = r_resp_valid;
  assign resp_product = r_resp_product;
  assign resp_err     = r_resp_err;
  assign busy         = r_busy;
  assign mul_start    = r_mul_start;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: multiplier model with random latency, a
// transaction-level reference model checked every cycle, directed and random traffic.
module tb_mult_share_arbiter;

  localparam int NR = 4;
  localparam int TO = 20;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [8*NR-1:0]     req_a = '0;
  logic [8*NR-1:0]     req_b = '0;
  logic [NR-1:0]       req_ack;
  logic [NR-1:0]       resp_valid;
  logic signed [15:0]  resp_product;
  logic                resp_err;
  logic                busy;
  logic                mul_start;
  logic signed [7:0]   mul_a;
  logic signed [7:0]   mul_b;
  logic                mul_done;
  logic signed [15:0]  mul_product;

  int n_vec = 0;
  int n_miss = 0;

  mult_share_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ack      (req_ack),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .busy         (busy),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product)
  );

  always #5 clock = ~clock;

  // Multiplier model: samples operands on start, random latency, done held until start drops.
  logic              stuck = 1'b0;
  logic              m_busy;
  int                m_cnt, m_lat;
  logic signed [7:0] m_a, m_b;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_done <= 1'b0; mul_product <= '0; m_busy <= 1'b0;
      m_cnt <= 0; m_lat <= 1; m_a <= '0; m_b <= '0;
    end else if (mul_done) begin
      if (!mul_start) mul_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt >= m_lat - 1) begin
        m_busy <= 1'b0;
        if (!stuck) begin
          mul_done    <= 1'b1;
          mul_product <= m_a * m_b;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (mul_start) begin
      m_busy <= 1'b1; m_cnt <= 0; m_lat <= int'($urandom_range(1, 8));
      m_a <= mul_a; m_b <= mul_b;
    end
  end

  // Inputs as the DUT saw them at the last rising edge.
  logic [NR-1:0]   s_valid;
  logic [8*NR-1:0] s_a, s_b;
  always @(posedge clock) begin
    s_valid <= req_valid; s_a <= req_a; s_b <= req_b;
  end

  // Reference model state: one op in flight, round-robin pointer, last response.
  bit                 m_free = 1'b1;
  int                 m_skip = 1, m_ptr = 0, m_owner = 0, m_age = 0;
  int                 start_len = 0, last_start_len = 0;
  logic signed [15:0] m_exp_p = '0, m_last_p = '0;
  logic               m_exp_e = 1'b0, m_last_e = 1'b0;
  logic [7:0]         m_op_a = '0, m_op_b = '0;
  int                 grant_log[$];

  always @(negedge clock) begin
    logic [NR-1:0] exp_ack;
    int g, pa, pb;
    if (!reset_n) begin
      n_vec++;
      if ((req_ack != 0) || (resp_valid != 0) || (resp_product != 0) || resp_err || busy ||
          mul_start || (mul_a != 0) || (mul_b != 0)) begin
        n_miss++;
        $display("FAIL reset_state: ack=%b rv=%b prod=%h err=%b busy=%b start=%b a=%h b=%h required all 0",
                 req_ack, resp_valid, resp_product, resp_err, busy, mul_start, mul_a, mul_b);
      end
      m_free = 1'b1; m_skip = 1; m_ptr = 0; m_age = 0; start_len = 0;
      m_last_p = '0; m_last_e = 1'b0;
    end else begin
      exp_ack = '0;
      g = -1;
      if (m_free && m_skip == 0 && s_valid != '0) begin
        for (int k = 0; k < NR; k++)
          if (g < 0 && s_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        exp_ack[g] = 1'b1;
      end
      n_vec++;
      if (req_ack != exp_ack) begin
        n_miss++; $display("FAIL grant: req_ack=%b required %b", req_ack, exp_ack);
      end
      n_vec++;
      if (busy != (!m_free || g >= 0)) begin
        n_miss++; $display("FAIL busy: busy=%b required %b", busy, (!m_free || g >= 0));
      end
      if (m_free && m_skip > 0) m_skip--;
      if (g >= 0) begin
        m_op_a = s_a[g*8 +: 8];
        m_op_b = s_b[g*8 +: 8];
        pa = $signed(m_op_a);
        pb = $signed(m_op_b);
        m_exp_p = stuck ? 16'sd0 : 16'(pa * pb);
        m_exp_e = stuck;
        m_owner = g; m_free = 1'b0; m_age = 0; m_ptr = (g + 1) % NR;
        grant_log.push_back(g);
        n_vec++;
        if (mul_a != m_op_a || mul_b != m_op_b) begin
          n_miss++; $display("FAIL operand_capture: mul_a=%h mul_b=%h required %h %h", mul_a, mul_b, m_op_a, m_op_b);
        end
      end
      if (resp_valid != '0) begin
        n_vec++;
        if (m_free || resp_valid != (NR'(1) << m_owner) || resp_product != m_exp_p || resp_err != m_exp_e) begin
          n_miss++;
          $display("FAIL response: rv=%b prod=%h err=%b required rv=%b prod=%h err=%b inflight=%b",
                   resp_valid, resp_product, resp_err, NR'(1) << m_owner, m_exp_p, m_exp_e, !m_free);
        end
        m_free = 1'b1; m_skip = 1; m_last_p = m_exp_p; m_last_e = m_exp_e;
      end else begin
        n_vec++;
        if (resp_product != m_last_p || resp_err != m_last_e) begin
          n_miss++; $display("FAIL resp_hold: prod=%h err=%b required %h %b", resp_product, resp_err, m_last_p, m_last_e);
        end
      end
      if (!m_free) begin
        m_age++;
        if (m_age > TO + 16) begin
          n_vec++; n_miss++;
          $display("FAIL op_watchdog: no response after %0d cycles, required within %0d", m_age, TO + 16);
          m_free = 1'b1; m_skip = 1;
        end
      end
      if (mul_start) begin
        start_len++;
        n_vec++;
        if (m_free || mul_a != m_op_a || mul_b != m_op_b) begin
          n_miss++; $display("FAIL start_operands: a=%h b=%h inflight=%b required %h %b inflight=1",
                             mul_a, mul_b, !m_free, m_op_a, m_op_b);
        end
      end else if (start_len > 0) begin
        n_vec++;
        if (m_exp_e ? (start_len != TO) : (start_len >= TO)) begin
          n_miss++; $display("FAIL start_length: %0d cycles, timeout op=%b (required %0d if timeout else <%0d)",
                             start_len, m_exp_e, TO, TO);
        end
        last_start_len = start_len;
        start_len = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++; $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      step();
      if (!busy) idle = 1'b1;
    end
    chk("idle_reached", idle, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output logic e, output logic [NR-1:0] ack1);
    bit got;
    got = 1'b0; p = '0; e = 1'b0;
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_valid[idx] = 1'b1;
    step();
    ack1 = req_ack;
    req_valid[idx] = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      if (resp_valid[idx]) begin
        got = 1'b1; p = resp_product; e = resp_err;
      end
    end
    chk("resp_arrived", got, 1);
    step();
  endtask

  task automatic hold_ops(input logic [NR-1:0] mask, input int total);
    int acks;
    acks = 0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*8 +: 8] = 8'($urandom);
      req_b[i*8 +: 8] = 8'($urandom);
    end
    req_valid = mask;
    for (int k = 0; k < 400 && acks < total; k++) begin
      step();
      for (int i = 0; i < NR; i++)
        if (req_ack[i]) begin
          acks++;
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
        end
    end
    req_valid = '0;
    chk("hold_ops_acks", acks, total);
    wait_idle();
  endtask

  int exp_cont[3] = '{0, 2, 0};
  int exp_fair[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    logic [15:0]   p;
    logic          e;
    logic [NR-1:0] a1;
    bit            seen;

    do_reset();

    single(0, 8'd5, 8'd3, p, e, a1);
    chk("single_ack", a1, 4'b0001);
    chk("single_product", p, 16'd15);
    chk("single_err", e, 0);

    single(1, 8'hFD, 8'd7, p, e, a1);
    chk("signed_ack", a1, 4'b0010);
    chk("signed_product", p, 16'hFFEB);
    chk("signed_err", e, 0);

    do_reset();
    grant_log.delete();
    hold_ops(4'b0101, 3);
    chk("contention_count", grant_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("contention_order", (grant_log.size() > i) ? grant_log[i] : -1, exp_cont[i]);

    do_reset();
    grant_log.delete();
    hold_ops(4'b1111, 8);
    chk("fair_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("fair_order", (grant_log.size() > i) ? grant_log[i] : -1, exp_fair[i]);

    stuck = 1'b1;
    single(1, 8'd9, 8'd9, p, e, a1);
    chk("timeout_ack", a1, 4'b0010);
    chk("timeout_product", p, 16'd0);
    chk("timeout_err", e, 1);
    chk("timeout_start_len", last_start_len, TO);
    stuck = 1'b0;

    req_a[2*8 +: 8] = 8'd9;
    req_b[2*8 +: 8] = 8'd9;
    req_valid[2] = 1'b1;
    step();
    req_valid[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (mul_start) seen = 1'b1;
    end
    chk("midrun_start_seen", seen, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_ctrl", {req_ack, resp_valid, resp_err, busy, mul_start}, 0);
    chk("rst_product", resp_product, 0);
    chk("rst_operands", {mul_a, mul_b}, 0);
    repeat (2) step();
    reset_n = 1'b1;
    single(3, 8'd2, 8'hFC, p, e, a1);
    chk("post_reset_ack", a1, 4'b1000);
    chk("post_reset_product", p, 16'hFFF8);
    chk("post_reset_err", e, 0);

    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ack[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_a[i*8 +: 8] = 8'($urandom);
            req_b[i*8 +: 8] = 8'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      step();
    end
    req_valid = '0;
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units, required completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "bench time limit reached");
  end

endmodule
